// File: rtl/ex.sv
// Execute stage: combinational ALU, HI/LO register pair, and an iterative
// 32-iteration restoring divider that stalls the front of the pipeline.

package ex_pkg;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADDU,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_LUI,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_MFHI,
    OP_MFLO,
    OP_MTHI,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } Oper_t;

endpackage

module ex
  import ex_pkg::*;
#(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  Oper_t       oper_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_write_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic [31:0] pc_i,
  output logic        wreg_write_o,
  output logic [4:0]  wreg_addr_o,
  output logic [31:0] wreg_data_o,
  output logic [31:0] pc_o,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } div_state_t;

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // {partial remainder, quotient being shifted in}
  logic [63:0] acc_q, acc_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        stall_div;
  logic [31:0] alu_res;

  // Operand preparation for the divider and the multiplier.
  logic        is_div;
  logic        is_sdiv;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic signed [63:0] op1_sx, op2_sx;
  logic [63:0] prod_s, prod_u;

  assign is_div       = (oper_i == OP_DIV) || (oper_i == OP_DIVU);
  assign is_sdiv      = (oper_i == OP_DIV);
  assign dividend_abs = (is_sdiv && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign divisor_abs  = (is_sdiv && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
  assign op1_sx       = {{32{reg1_i[31]}}, reg1_i};
  assign op2_sx       = {{32{reg2_i[31]}}, reg2_i};
  assign prod_s       = op1_sx * op2_sx;
  assign prod_u       = {32'd0, reg1_i} * {32'd0, reg2_i};

  // One restoring step: shift remainder/quotient left, trial-subtract divisor.
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [63:0] acc_step;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign rem_shift = {acc_q[63:32], acc_q[31]};
  assign trial     = rem_shift - {1'b0, divisor_q};
  assign acc_step  = trial[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                               : {trial[31:0],     acc_q[30:0], 1'b1};
  assign quo_res   = neg_quo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
  assign rem_res   = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // Divider FSM next state plus all HI/LO write sources; flush suppresses every side effect.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_div = 1'b0;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div && (reg2_i != 32'd0)) begin
            state_d   = S_RUN;
            cnt_d     = 5'd0;
            acc_d     = {32'd0, dividend_abs};
            divisor_d = divisor_abs;
            neg_quo_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d = is_sdiv && reg1_i[31];
            stall_div = 1'b1;
          end else begin
            case (oper_i)
              OP_MULT:  {hi_d, lo_d} = prod_s;
              OP_MULTU: {hi_d, lo_d} = prod_u;
              OP_MTHI:  hi_d = reg1_i;
              OP_MTLO:  lo_d = reg1_i;
              default:  ;
            endcase
          end
        end
        S_RUN: begin
          acc_d     = acc_step;
          cnt_d     = cnt_q + 5'd1;
          stall_div = 1'b1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // Held DIV operands are ignored here: the result retires and we go idle.
          hi_d    = rem_res;
          lo_d    = quo_res;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= HILO_RESET;
      lo_q      <= HILO_RESET;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Zero-latency ALU and HI/LO read-out.
  always_comb begin
    alu_res = 32'd0;
    case (oper_i)
      OP_ADDU: alu_res = reg1_i + reg2_i;
      OP_SUBU: alu_res = reg1_i - reg2_i;
      OP_AND:  alu_res = reg1_i & reg2_i;
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_NOR:  alu_res = ~(reg1_i | reg2_i);
      OP_SLT:  alu_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: alu_res = {31'd0, (reg1_i < reg2_i)};
      OP_LUI:  alu_res = {reg2_i[15:0], 16'h0000};
      OP_SLL:  alu_res = reg2_i << reg1_i[4:0];
      OP_SRL:  alu_res = reg2_i >> reg1_i[4:0];
      OP_SRA:  alu_res = $signed(reg2_i) >>> reg1_i[4:0];
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = 32'd0;
    endcase
  end

  assign wreg_write_o = wreg_write_i && !flush_i && !rst;
  assign wreg_addr_o  = rst ? 5'd0  : wreg_addr_i;
  assign wreg_data_o  = rst ? 32'd0 : alu_res;
  assign pc_o         = rst ? 32'd0 : pc_i;
  assign stall_req_o  = stall_div && !rst;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the execute stage: stimulus pushes expected GPR writes,
// a negedge monitor pops and compares them; HI/LO follow a behavioural model.

module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  Oper_t       oper_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        wreg_write_i;
  logic [4:0]  wreg_addr_i;
  logic [31:0] pc_i;
  logic        wreg_write_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic [31:0] pc_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  ex dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .oper_i       (oper_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .wreg_write_i (wreg_write_i),
    .wreg_addr_i  (wreg_addr_i),
    .pc_i         (pc_i),
    .wreg_write_o (wreg_write_o),
    .wreg_addr_o  (wreg_addr_o),
    .wreg_data_o  (wreg_data_o),
    .pc_o         (pc_o),
    .stall_req_o  (stall_req_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    Oper_t       op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_txn = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Architectural meaning of each operation, written from the ISA rules.
  function automatic logic [31:0] alu_ref(Oper_t op, logic [31:0] a, logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_LUI:  return b << 16;
      OP_SLL:  return b << (a % 32);
      OP_SRL:  return b >> (a % 32);
      OP_SRA:  return sb >>> (a % 32);
      OP_MFHI: return hi_m;
      OP_MFLO: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic writes_gpr(Oper_t op);
    return !(op inside {OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr, input logic fl);
    oper_i       = op;
    reg1_i       = a;
    reg2_i       = b;
    wreg_write_i = wr;
    flush_i      = fl;
    wreg_addr_i  = 5'($urandom_range(0, 31));
    pc_i         = $urandom;
  endtask

  // Single-cycle instruction checked against the model.
  task automatic issue(input Oper_t op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic        wr;
    longint      pa;
    longint      pb;
    logic [63:0] ua;
    logic [63:0] ub;
    wr = writes_gpr(op);
    drive(op, a, b, wr, fl);
    if (wr && !fl) sb_q.push_back('{op, wreg_addr_i, alu_ref(op, a, b), pc_i});
    if (!fl) begin
      case (op)
        OP_MULT: begin
          pa = longint'($signed(a));
          pb = longint'($signed(b));
          {hi_m, lo_m} = pa * pb;
        end
        OP_MULTU: begin
          ua = {32'd0, a};
          ub = {32'd0, b};
          {hi_m, lo_m} = ua * ub;
        end
        OP_MTHI: hi_m = a;
        OP_MTLO: lo_m = a;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Single-cycle GPR-writing instruction with a fixed expected result.
  task automatic issue_const(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expv);
    drive(op, a, b, 1'b1, 1'b0);
    sb_q.push_back('{op, wreg_addr_i, expv, pc_i});
    @(posedge clk);
    #1;
  endtask

  // Divide held until stall drops; optional flush in cycle flush_at (-1 = none).
  task automatic do_div(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    int     cnt;
    int     exp_cnt;
    logic   s;
    longint n;
    longint d;
    cnt = 0;
    drive(op, a, b, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      flush_i = (k == flush_at);
      @(negedge clk);
      s = stall_req_o;
      if (s) cnt++;
      @(posedge clk);
      #1;
      if (k == flush_at || !s) break;
    end
    flush_i = 1'b0;
    oper_i  = OP_NOP;
    if (b == 32'd0)        exp_cnt = 0;
    else if (flush_at >= 0) exp_cnt = flush_at;
    else                    exp_cnt = 33;
    if (b != 32'd0 && flush_at < 0) begin
      if (op == OP_DIV) begin
        n = longint'($signed(a));
        d = longint'($signed(b));
      end else begin
        n = longint'(a);
        d = longint'(b);
      end
      lo_m = 32'(n / d);
      hi_m = 32'(n % d);
    end
    check("div_stall_cycles", 32'(cnt), 32'(exp_cnt));
    check("div_hi", hi_o, hi_m);
    check("div_lo", lo_o, lo_m);
    $display("div %s %h / %h flush_at %0d: stall %0d, hi %h lo %h",
             op.name(), a, b, flush_at, cnt, hi_o, lo_o);
  endtask

  // Monitor: every presented GPR write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wreg_write_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got r%0d = %h, required no write", wreg_addr_o, wreg_data_o);
      end else begin
        e = sb_q.pop_front();
        check("wreg_data", wreg_data_o, e.data);
        check("wreg_addr", {27'd0, wreg_addr_o}, {27'd0, e.addr});
        check("pc", pc_o, e.pc);
        $display("txn %0d %s r%0d = %h", n_txn, e.op.name(), e.addr, wreg_data_o);
        n_txn++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    Oper_t       op;
    logic [31:0] a;
    logic [31:0] b;
    int          fa;

    // Reset with a live ADDU on the inputs: everything must read zero.
    rst = 1'b1;
    drive(OP_ADDU, 32'd5, 32'd7, 1'b1, 1'b0);
    wreg_addr_i = 5'd3;
    pc_i        = 32'h0000_0100;
    repeat (2) begin
      @(negedge clk);
      check("rst_wreg_write", {31'd0, wreg_write_o}, 32'd0);
      check("rst_wreg_addr", {27'd0, wreg_addr_o}, 32'd0);
      check("rst_wreg_data", wreg_data_o, 32'd0);
      check("rst_pc", pc_o, 32'd0);
      check("rst_stall", {31'd0, stall_req_o}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    issue_const(OP_ADDU, 32'd5, 32'd7, 32'd12);

    // Directed ALU corner cases.
    issue_const(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    issue_const(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue_const(OP_SRA,  32'd4, 32'h8000_0000, 32'hF800_0000);
    issue_const(OP_LUI,  32'd0, 32'h0000_1234, 32'h1234_0000);

    // Multiplies.
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFE);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu_hi", hi_o, 32'h0000_0001);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);
    issue_const(OP_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFE);

    // Divides, divide-by-zero, and flushes mid-run and at completion.
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
    check("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
    do_div(OP_DIVU, 32'd100, 32'd7, -1);
    check("divu_100_7_hi", hi_o, 32'd2);
    check("divu_100_7_lo", lo_o, 32'd14);
    do_div(OP_DIV, 32'd5, 32'd0, -1);
    check("div0_hi", hi_o, 32'd2);
    check("div0_lo", lo_o, 32'd14);
    do_div(OP_DIV, 32'd1000, 32'd3, 10);
    check("flush_run_hi", hi_o, 32'd2);
    check("flush_run_lo", lo_o, 32'd14);
    do_div(OP_DIVU, 32'd9, 32'd3, -1);
    check("divu_9_3_hi", hi_o, 32'd0);
    check("divu_9_3_lo", lo_o, 32'd3);
    do_div(OP_DIV, 32'd20, 32'd3, 33);
    check("flush_done_hi", hi_o, 32'd0);
    check("flush_done_lo", lo_o, 32'd3);
    issue_const(OP_MFHI, 32'd0, 32'd0, 32'd0);

    // Randomized instruction stream against the model.
    for (int i = 0; i < 150; i++) begin
      op = Oper_t'(5'($urandom_range(0, 20)));
      a  = rand_val();
      b  = rand_val();
      if (op == OP_DIV || op == OP_DIVU) begin
        if ($urandom_range(0, 5) == 0) b = 32'd0;
        if ($urandom_range(0, 4) == 0) fa = int'($urandom_range(0, 33));
        else                           fa = -1;
        do_div(op, a, b, fa);
      end else begin
        issue(op, a, b, ($urandom_range(0, 7) == 0));
      end
    end

    issue(OP_NOP, 32'd0, 32'd0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_hi", hi_o, hi_m);
    check("final_lo", lo_o, lo_m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
